// File: rtl/booth_divider_signed.sv
// Sequential signed divider, radix-2 non-restoring on operand magnitudes.
// Quotient truncates toward zero; the remainder takes the sign of the dividend.
module booth_divider_signed #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   a_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] m_r;
    logic             sq;
    logic             sr;
    logic             ovf_cap;

    logic [WIDTH-1:0] abs_dvd;
    logic [WIDTH-1:0] abs_dvs;
    logic             is_ovf;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   a_step;
    logic [WIDTH:0]   a_fix;

    assign abs_dvd = dividend[WIDTH-1] ? -dividend : dividend;
    assign abs_dvs = divisor[WIDTH-1] ? -divisor : divisor;
    assign is_ovf  = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);

    assign m_ext  = {1'b0, m_r};
    assign a_sh   = {a_r[WIDTH-1:0], q_r[WIDTH-1]};
    // Sign of the partial remainder selects restore-by-add or subtract
    assign a_step = a_r[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
    assign a_fix  = a_r[WIDTH] ? (a_r + m_ext) : a_r;

    assign busy = (state == S_ITER) || (state == S_FIX);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            a_r         <= '0;
            q_r         <= '0;
            m_r         <= '0;
            sq          <= 1'b0;
            sr          <= 1'b0;
            ovf_cap     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            state       <= S_DONE;
                        end else begin
                            q_r     <= abs_dvd;
                            m_r     <= abs_dvs;
                            a_r     <= '0;
                            sq      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            sr      <= dividend[WIDTH-1];
                            ovf_cap <= is_ovf;
                            cnt     <= '0;
                            state   <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    a_r <= a_step;
                    q_r <= {q_r[WIDTH-2:0], ~a_step[WIDTH]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_FIX;
                end
                S_FIX: begin
                    a_r         <= a_fix;
                    quotient    <= sq ? -q_r : q_r;
                    remainder   <= sr ? -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];
                    overflow    <= ovf_cap;
                    div_by_zero <= 1'b0;
                    state       <= S_DONE;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_divider_signed.sv
// Randomised bench for booth_divider_signed against an integer-division model.
// Also covers reset, latency, divide-by-zero, overflow and start handling.
module tb_booth_divider_signed;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    booth_divider_signed #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output logic ov);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            q = '1; r = a; dz = 1'b1; ov = 1'b0;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
            dz = 1'b0;
            ov = (sa == -128) && (sb == -1);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq, er;
        logic edz, eov, saw_busy;
        int cyc;
        model(a, b, eq, er, edz, eov);
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        cyc = 1;
        saw_busy = busy;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            saw_busy |= busy;
        end
        chk("latency", cyc, (b == 0) ? 1 : W + 2);
        chk("busy_seen", {31'd0, saw_busy}, {31'd0, b != 0});
        chk("quotient", {24'd0, quotient}, {24'd0, eq});
        chk("remainder", {24'd0, remainder}, {24'd0, er});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, edz});
        chk("overflow", {31'd0, overflow}, {31'd0, eov});
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int ndone, cyc;
        logic [W-1:0] ra, rb;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_q", {24'd0, quotient}, 32'd0);
        chk("rst_r", {24'd0, remainder}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);

        run_op(8'd100, 8'd7);
        run_op(8'h9C, 8'd7);
        run_op(8'd100, 8'hF9);
        run_op(8'h9C, 8'hF9);
        run_op(8'h80, 8'hFF);
        run_op(8'h80, 8'h01);
        run_op(8'h19, 8'h00);
        run_op(8'h7F, 8'h80);
        run_op(8'h80, 8'h80);

        // start held high; operands change mid-run
        @(negedge clk);
        dividend = 8'd50; divisor = 8'd3; start = 1'b1;
        ndone = 0;
        for (int i = 1; i <= W + 2; i++) begin
            @(negedge clk);
            if (i == 3) begin dividend = 8'd9; divisor = 8'd9; end
            if (done) ndone++;
            cyc = i;
            if (done) break;
        end
        chk("hold_lat", cyc, W + 2);
        chk("hold_ndone", ndone, 1);
        chk("hold_q", {24'd0, quotient}, 32'h10);
        chk("hold_r", {24'd0, remainder}, 32'h02);
        @(negedge clk);
        chk("hold_idle", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        chk("hold_accept", {31'd0, busy}, 32'd1);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin @(negedge clk); cyc++; end
        chk("second_lat", cyc, W + 2);
        chk("second_q", {24'd0, quotient}, 32'h01);
        chk("second_r", {24'd0, remainder}, 32'h00);

        // reset in the middle of an iteration
        @(negedge clk);
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_q", {24'd0, quotient}, 32'd0);
        chk("mid_rst_r", {24'd0, remainder}, 32'd0);
        chk("mid_rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        ndone = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mid_rst_nodone", ndone, 0);
        run_op(8'd7, 8'd7);

        for (int k = 0; k < 60; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (k % 10 == 3) rb = '0;
            if (k % 10 == 7) begin ra = 8'h80; rb = 8'hFF; end
            if (k % 10 == 8) rb = 8'h01;
            run_op(ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/booth_divider_signed.md
# booth_divider_signed

Sequential signed two's-complement divider using the radix-2 non-restoring algorithm. It is the inverse companion of the Booth multiplier datapath in this library. It takes a WIDTH-bit dividend and divisor and returns quotient and remainder after a fixed WIDTH+2 cycle latency. It uses a start/done handshake and sits next to the multiplier in the arithmetic unit.

## Interface
- WIDTH, 8, operand/result width in bits (WIDTH ≥ 4)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  signed two's-complement dividend; captured with start
- divisor  input  WIDTH  signed two's-complement divisor; captured with start
- quotient  output  WIDTH  signed quotient, truncated toward zero
- remainder  output  WIDTH  signed remainder; same sign as dividend, or zero
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when results update
- div_by_zero  output  1  set when last operation had divisor == 0
- overflow  output  1  set when last operation was most-negative / -1

## Operation
- States are IDLE, ITER, FIX and DONE. Register state, a log2(WIDTH)+1-bit counter, A[WIDTH:0], Q[WIDTH-1:0], M[WIDTH-1:0], and the two sign bits.
- IDLE with start=1, divisor≠0:
  - Q = |dividend| as unsigned, M = |divisor| as unsigned, A = 0.
  - Latch sq = dividend[MSB]^divisor[MSB] and sr = dividend[MSB].
  - Counter = 0, go to ITER.
- IDLE with start=1, divisor=0: go directly to DONE with quotient = all ones, remainder = dividend, div_by_zero = 1, overflow = 0.
- ITER, one step per cycle, WIDTH cycles:
  - Shift {A,Q} left by 1.
  - If the old A[WIDTH] = 0, A = A − M; otherwise A = A + M. Use WIDTH+1-bit arithmetic with M zero-extended.
  - Q[0] = ~A_new[WIDTH].
  - Counter increments. Leave to FIX when counter = WIDTH−1.
- FIX, one cycle:
  - If A[WIDTH] = 1, A = A + M.
  - quotient = sq ? −Q : Q.
  - remainder = sr ? −A[WIDTH-1:0] : A[WIDTH-1:0].
  - overflow = (dividend was most-negative and divisor was −1). Detect this at capture and store it in a flag.
  - div_by_zero = 0. Go to DONE.
- DONE: done = 1 for this cycle only, then go to IDLE. start is not accepted in DONE.
- Most-negative / −1 case: magnitude 2^(WIDTH−1) wraps, so quotient = 0x80 for WIDTH=8, remainder = 0, overflow = 1.
- start while busy or in DONE is ignored. There is no queuing.
- quotient, remainder, div_by_zero and overflow are registered. They change only on the FIX→DONE edge, or the IDLE→DONE edge in the divide-by-zero case, and hold until the next result.
- rst in any state, including mid-ITER, returns to IDLE on that edge. The in-flight operation is discarded.

## Timing
- Reset values: quotient = 0, remainder = 0, busy = 0, done = 0, div_by_zero = 0, overflow = 0, state = IDLE.
- The start-accept edge is edge 0.
  - busy is high from edge 0 until edge WIDTH+1, the FIX→DONE edge, then low.
  - busy is low in DONE.
  - done is high in the cycle after edge WIDTH+1.
  - Total latency from start-sample to the done cycle is WIDTH+2 cycles (10 for WIDTH=8).
- Divide-by-zero: done is high in the cycle after edge 0. busy never asserts.
- Back-to-back operation: earliest next accept is the cycle after done. Peak throughput is one result per WIDTH+3 cycles.
- Operands are sampled only on the accept edge. Later changes on dividend/divisor have no effect.

## Test plan
- Reset, then 100 / 7 (0x64 / 0x07) → done exactly 10 cycles after start. quotient = 0x0E, remainder = 0x02, both flags 0.
- −100 / 7 (0x9C / 0x07) → quotient = 0xF2 (−14), remainder = 0xFE (−2). Then 100 / −7 → quotient = 0xF2, remainder = 0x02. Then −100 / −7 → quotient = 0x0E, remainder = 0xFE.
- 0x80 / 0xFF (−128 / −1) → quotient = 0x80, remainder = 0x00, overflow = 1. Also 0x80 / 0x01 → quotient = 0x80, remainder = 0, overflow = 0.
- 25 / 0 (0x19 / 0x00) → done in the next cycle, busy stays 0. quotient = 0xFF, remainder = 0x19, div_by_zero = 1.
- Start 50 / 3 while holding start high, and change operands to 9 / 9 mid-run → exactly one done with quotient = 0x10, remainder = 0x02. The second start is accepted only after done.
- Assert rst for one cycle at ITER cycle 4 of 100 / 7 → next cycle: state IDLE, all outputs 0, no done pulse. A fresh 7 / 7 then yields quotient = 0x01, remainder = 0x00.
